mem_run_ctrl: RTL

Run-control sequencer and data-memory arbiter for the 9-bit-ISA single-cycle core. Owns the core's reset and clock-enable and shares the single 256x8 data memory between the core and a host port used by the bench or loader. The host preloads operands, pulses start, and the block runs the core until its PC reaches the halt address or a watchdog expires. The host then reads results back.

---
 rtl/run_ctrl_pkg.sv | 24 ++
 rtl/run_watchdog.sv | 49 ++++
 rtl/mem_run_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// ============================================================================
// Module      : run_ctrl_pkg
// Description : Shared run-control state encoding and default limits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package run_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CORE_RST = 3'd1,
      ST_RUN      = 3'd2,
      ST_HALT     = 3'd3,
      ST_TMO      = 3'd4
   } run_state_t;

   localparam int DONE_PC_DEF  = 510;
   localparam int WDOG_W_DEF   = 16;
   localparam int WDOG_MAX_DEF = 'hFFFF;

endpackage

`default_nettype wire

// File: rtl/run_watchdog.sv
// ============================================================================
// Module      : run_watchdog
// Description : RUN-cycle counter with limit compare; expire flags the last
//               permitted increment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module run_watchdog
   import run_ctrl_pkg::*;
#(
   parameter int WDOG_W   = WDOG_W_DEF,
   parameter int WDOG_MAX = WDOG_MAX_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inc,
   input  logic              clr,
   output logic [WDOG_W-1:0] count,
   output logic              expire
);

   localparam logic [WDOG_W-1:0] c_last = WDOG_W'(WDOG_MAX - 1);

   logic [WDOG_W-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count  = count_q;
   assign expire = inc && (count_q == c_last);

endmodule

`default_nettype wire

// File: rtl/mem_run_ctrl.sv
// ============================================================================
// Module      : mem_run_ctrl
// Description : Core run sequencer plus static host/core data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int AW       = 8,
   parameter int DW       = 8,
   parameter int PC_W     = 12,
   parameter int DONE_PC  = DONE_PC_DEF,
   parameter int WDOG_W   = WDOG_W_DEF,
   parameter int WDOG_MAX = WDOG_MAX_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [AW-1:0]     host_addr,
   input  logic [DW-1:0]     host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DW-1:0]     host_rdata,
   input  logic [PC_W-1:0]   core_pc,
   input  logic              core_we,
   input  logic [AW-1:0]     core_addr,
   input  logic [DW-1:0]     core_wdata,
   output logic [DW-1:0]     core_rdata,
   output logic              core_reset,
   output logic              core_en,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   input  logic [DW-1:0]     mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [WDOG_W-1:0] cycle_count
);

   localparam logic [PC_W-1:0] c_done_pc = PC_W'(DONE_PC);

   run_state_t    state_d, state_q;
   logic          done_d, done_q;
   logic          timeout_d, timeout_q;
   logic          host_rvalid_d, host_rvalid_q;
   logic [DW-1:0] host_rdata_d, host_rdata_q;
   logic          wd_clr;
   logic          wd_expire;
   logic          pc_at_done;
   logic          in_run;

   assign in_run     = (state_q == ST_RUN);
   assign pc_at_done = (core_pc == c_done_pc);
   // The halt-address instruction itself must never execute.
   assign core_en    = in_run && !pc_at_done;

   run_watchdog #(
      .WDOG_W   (WDOG_W),
      .WDOG_MAX (WDOG_MAX)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .inc    (core_en),
      .clr    (wd_clr),
      .count  (cycle_count),
      .expire (wd_expire)
   );

   always_comb begin
      state_d   = state_q;
      done_d    = done_q;
      timeout_d = timeout_q;
      wd_clr    = 1'b0;
      case (state_q)
         ST_IDLE, ST_HALT, ST_TMO: begin
            if (start) begin
               state_d = ST_CORE_RST;
            end
         end
         ST_CORE_RST: begin
            state_d   = ST_RUN;
            done_d    = 1'b0;
            timeout_d = 1'b0;
            wd_clr    = 1'b1;
         end
         ST_RUN: begin
            // Reaching the halt address wins over a simultaneous expiry.
            if (pc_at_done) begin
               state_d = ST_HALT;
               done_d  = 1'b1;
            end else if (wd_expire) begin
               state_d   = ST_TMO;
               timeout_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      host_gnt  = host_req && !in_run;
      mem_addr  = in_run ? core_addr  : host_addr;
      mem_wdata = in_run ? core_wdata : host_wdata;
      mem_we    = in_run ? (core_we && core_en) : (host_req && host_we);
      host_rvalid_d = host_gnt && !host_we;
      host_rdata_d  = host_rvalid_d ? mem_rdata : host_rdata_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         done_q        <= 1'b0;
         timeout_q     <= 1'b0;
         host_rvalid_q <= 1'b0;
         host_rdata_q  <= '0;
      end else begin
         state_q       <= state_d;
         done_q        <= done_d;
         timeout_q     <= timeout_d;
         host_rvalid_q <= host_rvalid_d;
         host_rdata_q  <= host_rdata_d;
      end
   end

   assign core_rdata  = mem_rdata;
   assign core_reset  = (state_q == ST_IDLE) || (state_q == ST_CORE_RST);
   assign busy        = (state_q == ST_CORE_RST) || in_run;
   assign done        = done_q;
   assign timeout     = timeout_q;
   assign host_rvalid = host_rvalid_q;
   assign host_rdata  = host_rdata_q;

endmodule

`default_nettype wire
